// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues ROM reads, absorbs the one-cycle
// ROM latency and buffers fetched words in a 2-entry FIFO toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] rom_memout,
  output logic [31:0] rom_addr,
  output logic        rom_en,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        halted,
  output logic        misalign_err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
  logic [1:0]        occ_q, occ_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              misalign_q, misalign_d;
  logic [XLEN-1:0]   mem_instr_q [DEPTH];
  logic [XLEN-1:0]   mem_pc_q    [DEPTH];

  logic              pop_c;
  logic              push_c;
  logic              room_c;
  logic              issue_c;
  logic [XLEN-1:0]   pc_plus4_c;
  logic [2:0]        pending_c;

  assign instr_valid  = (occ_q != 2'd0);
  assign instr        = mem_instr_q[rd_ptr_q];
  assign instr_pc     = mem_pc_q[rd_ptr_q];
  assign rom_addr     = pc_q;
  assign halted       = (state_q == ST_HALT);
  assign misalign_err = misalign_q;

  // Outstanding slots after this cycle's pop; a new issue needs one free
  assign pop_c      = instr_valid & instr_ready;
  assign pending_c  = 3'({1'b0, occ_q}) + 3'({2'b0, inflight_q}) - 3'({2'b0, pop_c});
  assign room_c     = (pending_c < 3'd2);
  assign issue_c    = (state_q == ST_RUN) & ~redirect_valid & room_c;
  assign rom_en     = issue_c & ~reset;
  assign push_c     = inflight_q & ~redirect_valid;
  assign pc_plus4_c = pc_q + 32'd4;

  // Next-state: redirect dominates issue, capture and pop bookkeeping
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    occ_d         = occ_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    misalign_d    = misalign_q;

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      occ_d      = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d    = ST_HALT;
        misalign_d = 1'b1;
      end else if (redirect_pc < PC_LIMIT) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_HALT;
      end
    end else begin
      if (pop_c) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push_c) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      occ_d = occ_q + 2'(push_c) - 2'(pop_c);
      if (issue_c) begin
        pc_d          = pc_plus4_c;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        if (pc_plus4_c == PC_LIMIT) begin
          state_d = ST_HALT;
        end
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      occ_q         <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      misalign_q    <= misalign_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else if (push_c) begin
      mem_instr_q[wr_ptr_q] <= rom_memout;
      mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered ROM model; checks the fetch
// pipeline, stall, redirect, end-of-ROM, misalignment and reset behaviour.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_memout;
  logic [31:0] rom_addr;
  logic        rom_en;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_memout     (rom_memout),
    .rom_addr       (rom_addr),
    .rom_en         (rom_en),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // One-cycle registered ROM
  always @(posedge clk) begin
    if (rom_en) rom_memout <= rom_word(rom_addr);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then let combinational outputs settle
  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    rom_memout = '0;

    // Reset state
    do_reset();
    check("rst_rom_en", 32'(rom_en), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_rom_addr", rom_addr, 32'h0);

    // 1: streaming fetch with decode always ready
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t1_c0_rom_en", 32'(rom_en), 32'd1);
    check("t1_c0_addr", rom_addr, 32'h0);
    check("t1_c0_valid", 32'(instr_valid), 32'd0);
    for (int k = 1; k < 8; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      check("t1_addr", rom_addr, 32'(4 * k));
      check("t1_rom_en", 32'(rom_en), 32'd1);
      check("t1_valid", 32'(instr_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        check("t1_instr_pc", instr_pc, 32'(4 * (k - 2)));
        check("t1_instr", instr, rom_word(32'(4 * (k - 2))));
      end
    end

    // 2: decode stalls, at most two outstanding, head stable, then drains in order
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_c0_addr", rom_addr, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_c1_addr", rom_addr, 32'h4);
    check("t2_c1_rom_en", 32'(rom_en), 32'd1);
    for (int k = 2; k < 7; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      check("t2_stall_rom_en", 32'(rom_en), 32'd0);
      check("t2_stall_valid", 32'(instr_valid), 32'd1);
      check("t2_stall_pc", instr_pc, 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_rel_pc0", instr_pc, 32'h0);
    check("t2_rel_addr", rom_addr, 32'h8);
    check("t2_rel_rom_en", 32'(rom_en), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_rel_pc4", instr_pc, 32'h4);
    check("t2_rel_valid4", 32'(instr_valid), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_rel_pc8", instr_pc, 32'h8);
    check("t2_rel_instr8", instr, rom_word(32'h8));

    // 3: redirect while a word is buffered and another in flight
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h28, 1'b0);
    check("t3_redir_rom_en", 32'(rom_en), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_post_valid", 32'(instr_valid), 32'd0);
    check("t3_post_rom_en", 32'(rom_en), 32'd1);
    check("t3_post_addr", rom_addr, 32'h28);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_nostale_valid", 32'(instr_valid), 32'd0);
    check("t3_addr2c", rom_addr, 32'h2C);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_first_valid", 32'(instr_valid), 32'd1);
    check("t3_first_pc", instr_pc, 32'h28);
    check("t3_first_instr", instr, rom_word(32'h28));
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_second_pc", instr_pc, 32'h2C);

    // 4: run to end of ROM, drain, then resume via redirect
    drive(1'b0, 1'b1, 32'h3F0, 1'b1);
    check("t4_redir_rom_en", 32'(rom_en), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_addr3f0", rom_addr, 32'h3F0);
    check("t4_valid0", 32'(instr_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_addr3f4", rom_addr, 32'h3F4);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_addr3f8", rom_addr, 32'h3F8);
    check("t4_pc3f0", instr_pc, 32'h3F0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_last_addr", rom_addr, 32'h3FC);
    check("t4_last_rom_en", 32'(rom_en), 32'd1);
    check("t4_last_halted", 32'(halted), 32'd0);
    check("t4_pc3f4", instr_pc, 32'h3F4);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_halt_rom_en", 32'(rom_en), 32'd0);
    check("t4_halt_pc_reg", rom_addr, 32'h400);
    check("t4_pc3f8", instr_pc, 32'h3F8);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_pc3fc", instr_pc, 32'h3FC);
    check("t4_instr3fc", instr, rom_word(32'h3FC));
    check("t4_halt_rom_en2", 32'(rom_en), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_drained", 32'(instr_valid), 32'd0);
    check("t4_still_halted", 32'(halted), 32'd1);
    check("t4_halt_rom_en3", 32'(rom_en), 32'd0);
    drive(1'b0, 1'b1, 32'h10, 1'b1);
    check("t4_resume_redir_en", 32'(rom_en), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_resume_halted", 32'(halted), 32'd0);
    check("t4_resume_rom_en", 32'(rom_en), 32'd1);
    check("t4_resume_addr", rom_addr, 32'h10);

    // 5: misaligned redirect halts with sticky error; aligned redirect resumes
    drive(1'b0, 1'b1, 32'h22, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_misalign", 32'(misalign_err), 32'd1);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_rom_en", 32'(rom_en), 32'd0);
    check("t5_valid", 32'(instr_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t5_rom_en2", 32'(rom_en), 32'd0);
    drive(1'b0, 1'b1, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t5_resume_halted", 32'(halted), 32'd0);
    check("t5_sticky", 32'(misalign_err), 32'd1);
    check("t5_resume_rom_en", 32'(rom_en), 32'd1);
    check("t5_resume_addr", rom_addr, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t5_addr4", rom_addr, 32'h4);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t5_head_pc0", instr_pc, 32'h0);
    check("t5_stall_rom_en", 32'(rom_en), 32'd0);

    // 6: reset with FIFO full and a concurrent redirect
    drive(1'b1, 1'b1, 32'h40, 1'b0);
    check("t6_full_valid", 32'(instr_valid), 32'd1);
    check("t6_rst_rom_en", 32'(rom_en), 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    check("t6_valid", 32'(instr_valid), 32'd0);
    check("t6_instr", instr, 32'h0);
    check("t6_instr_pc", instr_pc, 32'h0);
    check("t6_halted", 32'(halted), 32'd0);
    check("t6_misalign", 32'(misalign_err), 32'd0);
    check("t6_rom_addr", rom_addr, 32'h0);
    check("t6_rom_en", 32'(rom_en), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_restart_en", 32'(rom_en), 32'd1);
    check("t6_restart_addr", rom_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
